// File: rtl/morse_symbol_capture.sv
// Morse front end: synchronises the key, classifies presses as dot/dash on the
// timer tick base, packs up to five symbols per letter and flags letter/word gaps.
module morse_symbol_capture #(
  parameter int DASH_TICKS       = 3,
  parameter int LETTER_GAP_TICKS = 3,
  parameter int WORD_GAP_TICKS   = 7,
  parameter int CNT_W            = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  input  logic       tick,
  output logic       timer_en,
  output logic       timer_reconfig,
  output logic       letter_valid,
  output logic [2:0] letter_len,
  output logic [4:0] letter_pat,
  output logic       letter_ovf,
  output logic       word_space
);

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] DASH_C     = CNT_W'(DASH_TICKS);
  localparam logic [CNT_W-1:0] LETTER_C   = CNT_W'(LETTER_GAP_TICKS);
  localparam logic [CNT_W-1:0] WORD_C     = CNT_W'(WORD_GAP_TICKS);

  state_t           state;
  logic             key_meta, key_s, key_d;
  logic             rise, fall, sym;
  logic [CNT_W-1:0] press_cnt, gap_cnt, press_inc, gap_inc;
  logic [2:0]       len;
  logic [4:0]       pat;
  logic             ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_meta <= 1'b0;
      key_s    <= 1'b0;
      key_d    <= 1'b0;
    end else begin
      key_meta <= key_in;
      key_s    <= key_meta;
      key_d    <= key_s;
    end
  end

  assign rise = key_s & ~key_d;
  assign fall = ~key_s & key_d;

  // A tick landing on the release cycle still counts before classification.
  always_comb begin
    press_inc = press_cnt;
    gap_inc   = gap_cnt;
    if (tick && press_cnt != CNT_MAX) press_inc = press_cnt + 1'b1;
    if (tick && gap_cnt != CNT_MAX)   gap_inc   = gap_cnt + 1'b1;
    sym = (press_inc >= DASH_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      press_cnt      <= '0;
      gap_cnt        <= '0;
      len            <= '0;
      pat            <= '0;
      ovf            <= 1'b0;
      timer_en       <= 1'b0;
      timer_reconfig <= 1'b0;
      letter_valid   <= 1'b0;
      letter_len     <= '0;
      letter_pat     <= '0;
      letter_ovf     <= 1'b0;
      word_space     <= 1'b0;
    end else begin
      timer_reconfig <= 1'b0;
      letter_valid   <= 1'b0;
      letter_len     <= '0;
      letter_pat     <= '0;
      letter_ovf     <= 1'b0;
      word_space     <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state          <= PRESS;
            press_cnt      <= '0;
            timer_reconfig <= 1'b1;
            timer_en       <= 1'b1;
          end
        end
        PRESS: begin
          press_cnt <= press_inc;
          if (fall) begin
            if (len < 3'd5) begin
              pat <= {pat[3:0], sym};
              len <= len + 3'd1;
            end else begin
              ovf <= 1'b1;
            end
            state   <= GAP;
            gap_cnt <= '0;
          end
        end
        GAP: begin
          // The letter still closes on a threshold tick that coincides with a new press.
          if (tick && gap_inc == LETTER_C && len != 3'd0) begin
            letter_valid <= 1'b1;
            letter_len   <= len;
            letter_pat   <= pat;
            letter_ovf   <= ovf;
            len          <= '0;
            pat          <= '0;
            ovf          <= 1'b0;
          end
          if (rise) begin
            state          <= PRESS;
            press_cnt      <= '0;
            timer_reconfig <= 1'b1;
          end else begin
            gap_cnt <= gap_inc;
            if (tick && gap_inc == WORD_C) begin
              word_space <= 1'b1;
              state      <= IDLE;
              timer_en   <= 1'b0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          timer_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
